// File: rtl/window_frame_sequencer_if.sv
// rtl/window_frame_sequencer_if.sv - sample handshake, window FIFO and FFT-side output bundle
interface window_frame_sequencer_if #(
    parameter int ADDRWIDTH = 12,
    parameter int DATAWIDTH = 16
);
    logic                 enable;
    logic                 in_valid;
    logic                 in_ready;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_enqueue;
    logic                 fifo_dequeue;
    logic [DATAWIDTH-1:0] fifo_rd_data;
    logic [ADDRWIDTH-1:0] coef_addr;
    logic [DATAWIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_first;
    logic                 out_last;
    logic [15:0]          frames_done;
    logic                 busy;

    modport master (
        input  enable, in_valid, fifo_full, fifo_empty, fifo_rd_data, out_ready,
        output in_ready, fifo_enqueue, fifo_dequeue, coef_addr, out_data,
               out_valid, out_first, out_last, frames_done, busy
    );

    modport slave (
        output enable, in_valid, fifo_full, fifo_empty, fifo_rd_data, out_ready,
        input  in_ready, fifo_enqueue, fifo_dequeue, coef_addr, out_data,
               out_valid, out_first, out_last, frames_done, busy
    );
endinterface

// File: rtl/window_frame_sequencer.sv
// rtl/window_frame_sequencer.sv - 50%-overlap window framing: fills N samples, streams them, rewinds by N/2
module window_frame_sequencer #(
    parameter int ADDRWIDTH = 12,
    parameter int DATAWIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    window_frame_sequencer_if.master bus
);
    localparam logic [ADDRWIDTH:0] N_C    = (ADDRWIDTH+1)'(1) << ADDRWIDTH;
    localparam logic [ADDRWIDTH:0] H_C    = N_C >> 1;
    localparam logic [ADDRWIDTH:0] LAST_K = N_C - (ADDRWIDTH+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_REWIND} state_t;

    state_t               state_q, state_d;
    logic [ADDRWIDTH:0]   occ_q, occ_d, k_q, k_d;
    logic [15:0]          frames_q, frames_d;
    logic                 pend_q;
    logic [ADDRWIDTH:0]   pend_k_q;
    logic                 skid_valid_q, skid_valid_d;
    logic [DATAWIDTH-1:0] skid_data_q, skid_data_d;
    logic [ADDRWIDTH:0]   skid_k_q, skid_k_d;
    logic                 out_valid_q, out_valid_d, first_q, first_d, last_q, last_d;
    logic [DATAWIDTH-1:0] out_data_q, out_data_d;
    logic [ADDRWIDTH-1:0] coef_q, coef_d;

    logic [ADDRWIDTH:0]   occ_avail;
    logic                 in_ready, accept, drain, room, deq, load_en;
    logic [1:0]           inflight;
    logic [DATAWIDTH-1:0] load_data;
    logic [ADDRWIDTH:0]   load_k;

    // REWIND frees H slots this cycle, so a write may land in the same cycle.
    assign occ_avail = (state_q == S_REWIND) ? occ_q - H_C : occ_q;
    assign in_ready  = reset_n && (occ_avail < N_C) && !bus.fifo_full;
    assign accept    = bus.in_valid && in_ready;

    // Output register plus one skid entry absorb the 1-cycle read latency at full rate.
    assign drain    = out_valid_q && bus.out_ready;
    assign inflight = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q};
    assign room     = (inflight - {1'b0, drain}) < 2'd2;
    assign deq      = (state_q == S_STREAM) && (k_q < N_C) && !bus.fifo_empty && room;

    always_comb begin
        state_d  = state_q;
        occ_d    = occ_q + {{ADDRWIDTH{1'b0}}, accept};
        k_d      = k_q;
        frames_d = frames_q;
        case (state_q)
            S_IDLE: begin
                k_d = '0;
                if (bus.enable) state_d = S_FILL;
            end
            S_FILL: begin
                k_d = '0;
                if (!bus.enable)        state_d = S_IDLE;
                else if (occ_q >= N_C)  state_d = S_STREAM;
            end
            S_STREAM: begin
                if (deq) begin
                    k_d = k_q + (ADDRWIDTH+1)'(1);
                    if (k_q == LAST_K) state_d = S_REWIND;
                end
            end
            S_REWIND: begin
                occ_d    = occ_q - H_C + {{ADDRWIDTH{1'b0}}, accept};
                frames_d = frames_q + 16'd1;
                k_d      = '0;
                if (bus.enable && occ_d >= N_C) state_d = S_STREAM;
                else if (bus.enable)            state_d = S_FILL;
                else                            state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        coef_d       = coef_q;
        first_d      = first_q;
        last_d       = last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_k_d     = skid_k_q;
        load_en      = 1'b0;
        load_data    = bus.fifo_rd_data;
        load_k       = pend_k_q;
        if (!out_valid_q || drain) begin
            out_valid_d = 1'b0;
            if (skid_valid_q) begin
                load_en      = 1'b1;
                load_data    = skid_data_q;
                load_k       = skid_k_q;
                skid_valid_d = pend_q;
                skid_data_d  = bus.fifo_rd_data;
                skid_k_d     = pend_k_q;
            end else if (pend_q) begin
                load_en = 1'b1;
            end
        end else if (pend_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = bus.fifo_rd_data;
            skid_k_d     = pend_k_q;
        end
        if (load_en) begin
            out_valid_d = 1'b1;
            out_data_d  = load_data;
            coef_d      = load_k[ADDRWIDTH-1:0];
            first_d     = (load_k == '0);
            last_d      = (load_k == LAST_K);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            occ_q        <= '0;
            k_q          <= '0;
            frames_q     <= '0;
            pend_q       <= 1'b0;
            pend_k_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_k_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            coef_q       <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            k_q          <= k_d;
            frames_q     <= frames_d;
            pend_q       <= deq;
            pend_k_q     <= k_q;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_k_q     <= skid_k_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            coef_q       <= coef_d;
            first_q      <= first_d;
            last_q       <= last_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.fifo_enqueue = accept;
    assign bus.fifo_dequeue = deq;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.coef_addr    = coef_q;
    assign bus.out_first    = first_q;
    assign bus.out_last     = last_q;
    assign bus.frames_done  = frames_q;
    assign bus.busy         = (state_q != S_IDLE);
endmodule
